// File: rtl/seq_mux_n.sv
// -----------------------------------------------------------------------------
// seq_mux_n
//
// Purpose:
//   N-channel, W-bit-per-channel multiplexer with a registered output stage
//   and a valid/ready output handshake. Two selection modes:
//     - manual (mode=0): the channel comes from the s input
//     - scan   (mode=1): an internal pointer walks the channels round-robin,
//                        advancing only when a sample is actually loaded
//   A one-cycle scan_done pulse accompanies the sample from the last channel
//   of a scan pass.
//
// Optional feature:
//   Define SEQ_MUX_MASK_EN to add the en_mask[N-1:0] input (1 = channel
//   enabled). Scan skips disabled channels, manual selection of a disabled
//   channel loads nothing, and scan_done marks the highest enabled channel.
//   Without the macro every channel is treated as enabled.
//
// Parameters:
//   N   number of input channels (2..64)
//   W   bits per channel
//   SW  select/pointer width, 2**SW >= N
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   ip         in   N*W flattened channel data, channel k = ip[k*W +: W]
//   ip_vld     in   request to load one sample
//   s          in   manual channel select (mode=0)
//   mode       in   0 = manual, 1 = scan
//   en_mask    in   per-channel enable (only with SEQ_MUX_MASK_EN)
//   op         out  registered selected data
//   op_ch      out  channel index of the data in op
//   op_vld     out  op/op_ch hold a valid sample
//   op_rdy     in   consumer accepts the sample
//   scan_done  out  one-cycle pulse with the last channel of a scan pass
// -----------------------------------------------------------------------------
module seq_mux_n #(
  parameter int N  = 8,
  parameter int W  = 8,
  parameter int SW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] ip,
  input  logic           ip_vld,
  input  logic [SW-1:0]  s,
  input  logic           mode,
`ifdef SEQ_MUX_MASK_EN
  input  logic [N-1:0]   en_mask,
`endif
  output logic [W-1:0]   op,
  output logic [SW-1:0]  op_ch,
  output logic           op_vld,
  input  logic           op_rdy,
  output logic           scan_done
);

  localparam logic [SW-1:0] LAST_CH = SW'(N - 1);
  localparam logic [SW-1:0] ZERO_CH = {SW{1'b0}};
  localparam logic [SW-1:0] ONE_CH  = SW'(1);

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // True when sel names an existing, enabled channel. Out-of-range selects
  // (possible when N is not a power of two) match no k and report false.
  function automatic logic chan_ok(input logic [SW-1:0] sel,
                                   input logic [N-1:0]  mask);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (SW'(k) == sel) begin
        ok = mask[k];
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  // Circular search for the first enabled channel at or after start.
  // Returns {found, index}. The first pass covers start..N-1; the second
  // pass wraps to 0..start-1 and is only used if the first found nothing.
  function automatic logic [SW:0] scan_pick(input logic [N-1:0]  mask,
                                            input logic [SW-1:0] start);
    logic          hit_hi;
    logic          hit_lo;
    logic [SW-1:0] idx_hi;
    logic [SW-1:0] idx_lo;
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    idx_hi = ZERO_CH;
    idx_lo = ZERO_CH;
    for (int k = 0; k < N; k++) begin
      if (mask[k] && (SW'(k) >= start) && !hit_hi) begin
        hit_hi = 1'b1;
        idx_hi = SW'(k);
      end else begin
        hit_hi = hit_hi;
      end
      if (mask[k] && !hit_lo) begin
        hit_lo = 1'b1;
        idx_lo = SW'(k);
      end else begin
        hit_lo = hit_lo;
      end
    end
    if (hit_hi) begin
      return {1'b1, idx_hi};
    end else begin
      return {hit_lo, idx_lo};
    end
  endfunction

  // Highest-index enabled channel; defines the end of a scan pass.
  function automatic logic [SW-1:0] last_enabled(input logic [N-1:0] mask);
    logic [SW-1:0] idx;
    idx = ZERO_CH;
    for (int k = 0; k < N; k++) begin
      if (mask[k]) begin
        idx = SW'(k);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Data slice for channel ch; unmatched indices yield zero.
  function automatic logic [W-1:0] chan_data(input logic [N*W-1:0] data,
                                             input logic [SW-1:0]  ch);
    logic [W-1:0] d;
    d = {W{1'b0}};
    for (int k = 0; k < N; k++) begin
      if (SW'(k) == ch) begin
        d = data[k*W +: W];
      end else begin
        d = d;
      end
    end
    return d;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [W-1:0]  op_q,        op_d;
  logic [SW-1:0] op_ch_q,     op_ch_d;
  logic          op_vld_q,    op_vld_d;
  logic          scan_done_q, scan_done_d;
  logic [SW-1:0] ptr_q,       ptr_d;

  logic [N-1:0]  mask;
  logic          free;
  logic          found;
  logic [SW-1:0] sel_ch;
  logic [SW:0]   pick;
  logic          load;
  logic [SW-1:0] ptr_next;

  // Effective channel enables: the mask port when compiled in, else all on.
`ifdef SEQ_MUX_MASK_EN
  assign mask = en_mask;
`else
  assign mask = {N{1'b1}};
`endif

  // Channel selection, load decision and next-state for the output stage.
  always_comb begin
    free        = !op_vld_q || op_rdy;
    pick        = scan_pick(mask, ptr_q);
    found       = 1'b0;
    sel_ch      = ZERO_CH;
    load        = 1'b0;
    ptr_next    = ZERO_CH;
    op_d        = op_q;
    op_ch_d     = op_ch_q;
    op_vld_d    = op_vld_q;
    scan_done_d = 1'b0;
    ptr_d       = ptr_q;

    if (mode) begin
      found  = pick[SW];
      sel_ch = pick[SW-1:0];
    end else begin
      found  = chan_ok(s, mask);
      sel_ch = s;
    end

    load = free && ip_vld && found;

    // Pointer continues just past the channel that was served, wrapping at
    // N-1; with no masking sel_ch equals ptr_q so this is plain round-robin.
    if (sel_ch == LAST_CH) begin
      ptr_next = ZERO_CH;
    end else begin
      ptr_next = sel_ch + ONE_CH;
    end

    if (load) begin
      op_d        = chan_data(ip, sel_ch);
      op_ch_d     = sel_ch;
      op_vld_d    = 1'b1;
      scan_done_d = mode && (sel_ch == last_enabled(mask));
    end else if (free) begin
      op_vld_d    = 1'b0;
    end else begin
      // Stalled: hold everything; scan_done stays a single-cycle pulse.
      op_vld_d    = op_vld_q;
    end

    // Manual mode parks the pointer at 0 so the next scan starts at channel 0.
    if (!mode) begin
      ptr_d = ZERO_CH;
    end else if (load) begin
      ptr_d = ptr_next;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Output register stage and scan pointer, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= {W{1'b0}};
      op_ch_q     <= ZERO_CH;
      op_vld_q    <= 1'b0;
      scan_done_q <= 1'b0;
      ptr_q       <= ZERO_CH;
    end else begin
      op_q        <= op_d;
      op_ch_q     <= op_ch_d;
      op_vld_q    <= op_vld_d;
      scan_done_q <= scan_done_d;
      ptr_q       <= ptr_d;
    end
  end

  assign op        = op_q;
  assign op_ch     = op_ch_q;
  assign op_vld    = op_vld_q;
  assign scan_done = scan_done_q;

endmodule

// File: tb/tb_seq_mux_n.sv
module tb_seq_mux_n;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int SW = 3;

  logic           clk;
  logic           rst;
  logic [N*W-1:0] ip;
  logic           ip_vld;
  logic [SW-1:0]  s;
  logic           mode;
  logic [W-1:0]   op;
  logic [SW-1:0]  op_ch;
  logic           op_vld;
  logic           op_rdy;
  logic           scan_done;
`ifdef SEQ_MUX_MASK_EN
  logic [N-1:0]   en_mask;
`endif

  int checks = 0;
  int passed = 0;

  seq_mux_n #(.N(N), .W(W), .SW(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ip        (ip),
    .ip_vld    (ip_vld),
    .s         (s),
    .mode      (mode),
`ifdef SEQ_MUX_MASK_EN
    .en_mask   (en_mask),
`endif
    .op        (op),
    .op_ch     (op_ch),
    .op_vld    (op_vld),
    .op_rdy    (op_rdy),
    .scan_done (scan_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Channel k carries 8'hA0 + k (or base + k).
  task automatic load_ip(input logic [7:0] base);
    for (int k = 0; k < N; k++) begin
      ip[k*W +: W] = base + 8'(k);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ip_vld = 1'b1; mode = 1'b0; s = 3'd3; op_rdy = 1'b1;
    load_ip(8'hA0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({op, op_ch, op_vld, scan_done} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
        $display("FAIL reset_hold cyc%0d: op=%h ch=%0d vld=%b done=%b, want 00/0/0/0", i, op, op_ch, op_vld, scan_done);
      end else passed++;
    end
    rst = 1'b0;
    checks++;
    if (op_vld !== 1'b0) $display("FAIL reset_release_pre: vld=%b want 0", op_vld);
    else passed++;
    tick();
    checks++;
    if ({op, op_ch, op_vld} !== {8'hA3, 3'd3, 1'b1}) begin
      $display("FAIL reset_first_load: op=%h ch=%0d vld=%b want A3/3/1", op, op_ch, op_vld);
    end else passed++;
  endtask

  task automatic test_manual();
    logic [SW-1:0] sel [2];
    sel[0] = 3'd7; sel[1] = 3'd0;
    for (int i = 0; i < 2; i++) begin
      s = sel[i];
      tick();
      checks++;
      if ({op, op_ch, op_vld, scan_done} !== {8'hA0 + 8'(sel[i]), sel[i], 1'b1, 1'b0}) begin
        $display("FAIL manual_s%0d: op=%h ch=%0d vld=%b done=%b want %h/%0d/1/0", sel[i], op, op_ch, op_vld, scan_done, 8'hA0 + 8'(sel[i]), sel[i]);
      end else passed++;
    end
  endtask

  task automatic test_scan_backpressure();
    do_reset();
    mode = 1'b1; ip_vld = 1'b1; op_rdy = 1'b1; load_ip(8'hA0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({op, op_ch, op_vld} !== {8'hA0 + 8'(i), 3'(i), 1'b1}) begin
        $display("FAIL scan_ch%0d: op=%h ch=%0d vld=%b", i, op, op_ch, op_vld);
      end else passed++;
    end
    op_rdy = 1'b0; load_ip(8'h50);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({op, op_ch, op_vld, scan_done} !== {8'hA2, 3'd2, 1'b1, 1'b0}) begin
        $display("FAIL scan_stall%0d: op=%h ch=%0d vld=%b done=%b want A2/2/1/0", i, op, op_ch, op_vld, scan_done);
      end else passed++;
    end
    op_rdy = 1'b1; load_ip(8'hA0);
    for (int i = 3; i < 8; i++) begin
      tick();
      checks++;
      if ({op, op_ch, op_vld, scan_done} !== {8'hA0 + 8'(i), 3'(i), 1'b1, (i == 7)}) begin
        $display("FAIL scan_resume%0d: op=%h ch=%0d vld=%b done=%b", i, op, op_ch, op_vld, scan_done);
      end else passed++;
    end
    tick();
    checks++;
    if ({op_ch, op_vld, scan_done} !== {3'd0, 1'b1, 1'b0}) begin
      $display("FAIL scan_wrap: ch=%0d vld=%b done=%b want 0/1/0", op_ch, op_vld, scan_done);
    end else passed++;
  endtask

  task automatic test_reset_mid_stall();
    // ptr is 1 here; five loads take op_ch to 5.
    for (int i = 0; i < 5; i++) tick();
    op_rdy = 1'b0;
    tick();
    checks++;
    if ({op_ch, op_vld} !== {3'd5, 1'b1}) $display("FAIL stall_setup: ch=%0d vld=%b want 5/1", op_ch, op_vld);
    else passed++;
    rst = 1'b1;
    tick();
    checks++;
    if ({op, op_ch, op_vld, scan_done} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
      $display("FAIL reset_mid_stall: op=%h ch=%0d vld=%b done=%b want 00/0/0/0", op, op_ch, op_vld, scan_done);
    end else passed++;
    rst = 1'b0; op_rdy = 1'b1;
    tick();
    checks++;
    if ({op_ch, op_vld} !== {3'd0, 1'b1}) $display("FAIL post_reset_scan: ch=%0d vld=%b want 0/1", op_ch, op_vld);
    else passed++;
  endtask

  task automatic test_no_request();
    ip_vld = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({op_ch, op_vld} !== {3'd0, 1'b0}) $display("FAIL idle%0d: ch=%0d vld=%b want 0/0", i, op_ch, op_vld);
      else passed++;
    end
    ip_vld = 1'b1;
    tick();
    checks++;
    if ({op_ch, op_vld} !== {3'd1, 1'b1}) $display("FAIL idle_resume: ch=%0d vld=%b want 1/1", op_ch, op_vld);
    else passed++;
  endtask

  task automatic test_mode_switch();
    tick(); tick(); tick();  // ch2, ch3, ch4 -> ptr now 5
    checks++;
    if (op_ch !== 3'd4) $display("FAIL switch_setup: ch=%0d want 4", op_ch);
    else passed++;
    mode = 1'b0; s = 3'd6;
    tick();
    checks++;
    if ({op, op_ch, op_vld, scan_done} !== {8'hA6, 3'd6, 1'b1, 1'b0}) begin
      $display("FAIL switch_manual: op=%h ch=%0d vld=%b done=%b want A6/6/1/0", op, op_ch, op_vld, scan_done);
    end else passed++;
    mode = 1'b1;
    tick();
    checks++;
    if ({op, op_ch, op_vld} !== {8'hA0, 3'd0, 1'b1}) begin
      $display("FAIL switch_back_scan: op=%h ch=%0d vld=%b want A0/0/1", op, op_ch, op_vld);
    end else passed++;
  endtask

`ifdef SEQ_MUX_MASK_EN
  task automatic test_mask();
    logic [SW-1:0] exp_ch [4];
    exp_ch[0] = 3'd1; exp_ch[1] = 3'd4; exp_ch[2] = 3'd7; exp_ch[3] = 3'd1;
    en_mask = 8'b1001_0010;
    do_reset();
    mode = 1'b1; ip_vld = 1'b1; op_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({op_ch, op_vld, scan_done} !== {exp_ch[i], 1'b1, (i == 2)}) begin
        $display("FAIL mask_scan%0d: ch=%0d vld=%b done=%b want %0d/1/%0d", i, op_ch, op_vld, scan_done, exp_ch[i], (i == 2));
      end else passed++;
    end
    en_mask = 8'b0000_0000;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (op_vld !== 1'b0) $display("FAIL mask_empty%0d: vld=%b want 0", i, op_vld);
      else passed++;
    end
    en_mask = 8'hFF;
  endtask
`endif

  initial begin
    rst = 1'b1; ip = '0; ip_vld = 1'b0; s = 3'd0; mode = 1'b0; op_rdy = 1'b1;
`ifdef SEQ_MUX_MASK_EN
    en_mask = 8'hFF;
`endif
    test_reset();
    test_manual();
    test_scan_backpressure();
    test_reset_mid_stall();
    test_no_request();
    test_mode_switch();
`ifdef SEQ_MUX_MASK_EN
    test_mask();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
